// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the six-digit seven-segment scan controller.
package disp_pkg;
  localparam int NUM_DIG = 6;
  localparam int IDX_W   = $clog2(NUM_DIG);
  localparam logic [6:0] SEG_0 = 7'h3F, SEG_1 = 7'h06, SEG_2 = 7'h5B, SEG_3 = 7'h4F,
                         SEG_4 = 7'h66, SEG_5 = 7'h6D, SEG_6 = 7'h7D, SEG_7 = 7'h07,
                         SEG_8 = 7'h7F, SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77, SEG_B = 7'h7C, SEG_C = 7'h39,
                         SEG_D = 7'h5E, SEG_E = 7'h79, SEG_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_RST   = SEG_0;
  typedef struct packed {
    logic [4*NUM_DIG-1:0] digits;
    logic [NUM_DIG-1:0]   dp;
  } disp_frame_t;
endpackage

// File: rtl/disp_nco.sv
// disp_nco: phase accumulator whose registered carry-out is the scan tick.
module disp_nco #(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCO_W-1:0] i_nco_num,
  output logic             o_tick
);
  logic [NCO_W-1:0] r_acc;
  logic             r_tick;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_tick, r_acc} <= '0;
    else        {r_tick, r_acc} <= {1'b0, r_acc} + {1'b0, i_nco_num};
  assign o_tick = r_tick;
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: double-buffered six-digit seven-segment scanner, loads taken at frame wrap.
// Define DISP_HEX_EN to render codes 10-15 as A-F; otherwise they are blank.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NCO_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCO_W-1:0]     i_nco_num,
  input  logic [4*NUM_DIG-1:0] i_digits,
  input  logic [NUM_DIG-1:0]   i_dp,
  input  logic                 i_load,
  output logic                 o_load_ack,
  output logic                 o_frame,
  output logic [6:0]           o_seg,
  output logic                 o_seg_dp,
  output logic [NUM_DIG-1:0]   o_seg_enb
);
  function automatic logic [6:0] f_dec(input logic [3:0] c);
    case (c)
      4'h0: f_dec = SEG_0;
      4'h1: f_dec = SEG_1;
      4'h2: f_dec = SEG_2;
      4'h3: f_dec = SEG_3;
      4'h4: f_dec = SEG_4;
      4'h5: f_dec = SEG_5;
      4'h6: f_dec = SEG_6;
      4'h7: f_dec = SEG_7;
      4'h8: f_dec = SEG_8;
      4'h9: f_dec = SEG_9;
`ifdef DISP_HEX_EN
      4'hA: f_dec = SEG_A;
      4'hB: f_dec = SEG_B;
      4'hC: f_dec = SEG_C;
      4'hD: f_dec = SEG_D;
      4'hE: f_dec = SEG_E;
      4'hF: f_dec = SEG_F;
`endif
      default: f_dec = SEG_BLANK;
    endcase
  endfunction

  logic              w_tick;
  logic              w_wrap;
  logic              w_take;
  logic [IDX_W-1:0]  r_idx;
  logic              r_pend;
  disp_frame_t       r_act;
  disp_frame_t       r_stg;

  disp_nco #(.NCO_W(NCO_W)) u_nco (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_nco_num (i_nco_num),
    .o_tick    (w_tick)
  );

  assign w_wrap = w_tick && r_idx == IDX_W'(NUM_DIG - 1);
  assign w_take = w_wrap && (i_load || r_pend);

  // A load coinciding with the wrap bypasses staging so it shows without a frame of delay.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx      <= '0;
      r_pend     <= 1'b0;
      r_act      <= '0;
      r_stg      <= '0;
      o_load_ack <= 1'b0;
      o_frame    <= 1'b0;
      o_seg      <= SEG_RST;
      o_seg_dp   <= 1'b0;
      o_seg_enb  <= NUM_DIG'(1);
    end else begin
      if (w_tick) r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      if (i_load) r_stg <= '{digits: i_digits, dp: i_dp};
      if (w_take) r_act <= i_load ? '{digits: i_digits, dp: i_dp} : r_stg;
      r_pend     <= w_wrap ? 1'b0 : (r_pend || i_load);
      o_load_ack <= w_take;
      o_frame    <= w_wrap;
      o_seg      <= f_dec(r_act.digits[4*r_idx +: 4]);
      o_seg_dp   <= r_act.dp[r_idx];
      o_seg_enb  <= NUM_DIG'(1) << r_idx;
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: randomized self-checking bench against a cycle-level behavioural model.
module tb_disp_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] nco = '0;
  logic [23:0] digits = '0;
  logic [5:0]  dp = '0;
  logic        load = 1'b0;
  logic        ack, frame, seg_dp;
  logic [6:0]  seg;
  logic [5:0]  enb;
  int total = 0;
  int bad = 0;

  disp_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_nco_num  (nco),
    .i_digits   (digits),
    .i_dp       (dp),
    .i_load     (load),
    .o_load_ack (ack),
    .o_frame    (frame),
    .o_seg      (seg),
    .o_seg_dp   (seg_dp),
    .o_seg_enb  (enb)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef DISP_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  // model: phase as a plain integer, digit position, shown and waiting data
  longint      m_phase;
  bit          m_tick;
  int          m_idx;
  bit          m_pend;
  logic [23:0] m_show, m_wait;
  logic [5:0]  m_show_dp, m_wait_dp;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame, e_ack;
  logic [5:0]  e_enb;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    return (c > 9 && !HEX) ? 7'h00 : seg_tab[c];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_tick = 0; m_idx = 0; m_pend = 0;
    m_show = '0; m_wait = '0; m_show_dp = '0; m_wait_dp = '0;
    e_seg = 7'h3F; e_dp = 0; e_enb = 6'b000001; e_frame = 0; e_ack = 0;
  endtask

  task automatic step();
    bit frame_end;
    longint nxt;
    @(posedge clk);
    e_seg = glyph(m_show[4*m_idx +: 4]);
    e_dp = m_show_dp[m_idx];
    e_enb = 6'(1 << m_idx);
    frame_end = m_tick && m_idx == 5;
    e_frame = frame_end;
    e_ack = frame_end && (m_pend || load);
    if (frame_end && load) begin m_show = digits; m_show_dp = dp; m_pend = 0; end
    else if (frame_end && m_pend) begin m_show = m_wait; m_show_dp = m_wait_dp; m_pend = 0; end
    else if (load) begin m_wait = digits; m_wait_dp = dp; m_pend = 1; end
    if (m_tick) m_idx = (m_idx + 1) % 6;
    nxt = m_phase + longint'(nco);
    m_tick = nxt >= 64'h1_0000_0000;
    m_phase = nxt % 64'h1_0000_0000;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; nco = 0; load = 0; model_reset();
    repeat (3) @(negedge clk);
    total++; if (seg !== 7'h3F) begin bad++; $display("FAIL reset_seg got=%h want=3f", seg); end
    total++; if (seg_dp !== 1'b0) begin bad++; $display("FAIL reset_dp got=%b want=0", seg_dp); end
    total++; if (enb !== 6'b000001) begin bad++; $display("FAIL reset_enb got=%b want=000001", enb); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", ack); end
    total++; if (frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", frame); end
    rst_n = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      total++; if (enb !== 6'b000001 || frame !== 1'b0) begin
        bad++; $display("FAIL freeze_enb cyc=%0d got=%b/%b want=000001/0", i, enb, frame);
      end
    end
  endtask

  task automatic test_scan();
    int last_f = -1;
    logic [5:0] prev;
    nco = 32'h8000_0000;
    prev = enb;
    for (int i = 0; i < 60; i++) begin
      step();
      total++; if (enb !== e_enb) begin bad++; $display("FAIL scan_enb cyc=%0d got=%b want=%b", i, enb, e_enb); end
      if (enb !== prev) begin
        total++; if (enb !== {prev[4:0], prev[5]}) begin
          bad++; $display("FAIL scan_walk got=%b want=%b", enb, {prev[4:0], prev[5]});
        end
      end
      if (frame === 1'b1) begin
        if (last_f >= 0) begin
          total++; if (i - last_f != 12) begin bad++; $display("FAIL frame_period got=%0d want=12", i - last_f); end
        end
        last_f = i;
      end
      prev = enb;
    end
    total++; if (last_f < 0) begin bad++; $display("FAIL frame_seen got=none want=pulse"); end
  endtask

  task automatic wait_idx(input int target, input string nm);
    int k = 0;
    while (m_idx != target && k < 40) begin step(); k++; end
    if (m_idx != target) begin
      total++; bad++; $display("FAIL %s_wait got=timeout want=idx%0d", nm, target);
    end
  endtask

  task automatic test_load();
    int acks = 0;
    bit s0 = 0, s5 = 0;
    wait_idx(2, "load");
    digits = 24'h123456; dp = 6'b0; load = 1;
    step(); load = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (ack === 1'b1) acks++;
      total++; if (ack !== e_ack || (ack === 1'b1 && frame !== 1'b1)) begin
        bad++; $display("FAIL load_ack cyc=%0d got=%b frame=%b want=%b", i, ack, frame, e_ack);
      end
    end
    total++; if (acks != 1) begin bad++; $display("FAIL load_ack_count got=%0d want=1", acks); end
    for (int i = 0; i < 12; i++) begin
      step();
      if (enb === 6'b000001) begin
        s0 = 1; total++; if (seg !== 7'h7D) begin bad++; $display("FAIL load_dig0 got=%h want=7d", seg); end
      end
      if (enb === 6'b100000) begin
        s5 = 1; total++; if (seg !== 7'h06) begin bad++; $display("FAIL load_dig5 got=%h want=06", seg); end
      end
    end
    total++; if (!(s0 && s5)) begin bad++; $display("FAIL load_digits_seen got=%b%b want=11", s0, s5); end
  endtask

  task automatic test_double_load();
    int acks = 0;
    wait_idx(1, "dbl");
    digits = 24'h111111; load = 1;
    step(); load = 0;
    step();
    digits = 24'h222222; load = 1;
    step(); load = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (ack === 1'b1) acks++;
    end
    total++; if (acks != 1) begin bad++; $display("FAIL dbl_ack_count got=%0d want=1", acks); end
    for (int i = 0; i < 12; i++) begin
      step();
      total++; if (seg !== 7'h5B) begin bad++; $display("FAIL dbl_seg enb=%b got=%h want=5b", enb, seg); end
    end
  endtask

  task automatic test_simul_wrap();
    int k = 0;
    while (!(m_tick && m_idx == 5) && k < 40) begin step(); k++; end
    total++; if (!(m_tick && m_idx == 5)) begin bad++; $display("FAIL simul_wait got=timeout want=wrap"); end
    digits = 24'h654329; dp = 6'b000001; load = 1;
    step(); load = 0;
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL simul_ack got=%b want=1", ack); end
    step();
    total++; if (enb !== 6'b000001 || seg !== 7'h6F || seg_dp !== 1'b1) begin
      bad++; $display("FAIL simul_show got=%b/%h/%b want=000001/6f/1", enb, seg, seg_dp);
    end
  endtask

  task automatic test_hex();
    bit seen = 0;
    logic [6:0] want;
    want = HEX ? 7'h7C : 7'h00;
    digits = 24'h00000B; dp = 6'b000001; load = 1;
    step(); load = 0;
    repeat (24) step();
    for (int i = 0; i < 12; i++) begin
      step();
      if (enb === 6'b000001) begin
        seen = 1;
        total++; if (seg !== want || seg_dp !== 1'b1) begin
          bad++; $display("FAIL hex_seg got=%h/%b want=%h/1", seg, seg_dp, want);
        end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL hex_seen got=none want=digit0"); end
  endtask

  task automatic test_reset_mid_load();
    int acks = 0;
    wait_idx(3, "rml");
    digits = 24'h777777; load = 1;
    step(); load = 0;
    #2 rst_n = 0; model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ack === 1'b1) acks++;
      if (enb === 6'b000001) begin
        total++; if (seg !== 7'h3F) begin bad++; $display("FAIL rml_seg got=%h want=3f", seg); end
      end
    end
    total++; if (acks != 0) begin bad++; $display("FAIL rml_ack got=%0d want=0", acks); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) nco = ($urandom % 6 == 0) ? 32'h0 : $urandom_range(32'hFFFF_FFFF, 32'h2000_0000);
      load = ($urandom % 9 == 0);
      digits = $urandom;
      dp = 6'($urandom);
      step();
      total++; if ({seg, seg_dp, enb, frame, ack} !== {e_seg, e_dp, e_enb, e_frame, e_ack}) begin
        bad++;
        $display("FAIL rand cyc=%0d got seg=%h dp=%b enb=%b fr=%b ack=%b want seg=%h dp=%b enb=%b fr=%b ack=%b",
                 i, seg, seg_dp, enb, frame, ack, e_seg, e_dp, e_enb, e_frame, e_ack);
      end
    end
    load = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_double_load();
    test_simul_wrap();
    test_hex();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
